// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder family.
//   - Default operand width and slice width.
//   - Helper that turns (width, slice width) into the number of pipeline stages,
//     which is also the latency in cycles from input transfer to valid result.
package pipelined_adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 8;
  localparam int ADDER_DEFAULT_CHUNK = 4;

  // One register stage per slice, so the stage count is simply the slice count.
  function automatic int adderStages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple-carry full-adder slice.
// Ports:
//   a, b      in   CHUNK  operand bits of this slice
//   ci        in   1      carry into the slice LSB
//   s         out  CHUNK  slice sum
//   co        out  1      carry out of the slice MSB
//   c_msb_in  out  1      carry into the slice MSB (for signed overflow detection)
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int CHUNK = ADDER_DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] carry;

  // Plain ripple chain; carry[i] is the carry into bit i of the slice.
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = carry[CHUNK];
  assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: carry-pipelined adder/subtractor with valid/ready flow control.
// The WIDTH-bit operation is split into CHUNK-bit slices; slice k works on bits
// [k*CHUNK +: CHUNK] one cycle after slice k-1, using the carry it registered.
// Latency is STAGES = WIDTH/CHUNK cycles, throughput one result per clock.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   a, b, cin, sub        operands, carry-in (add only), 1 = a - b
//   out_valid / out_ready output handshake
//   sum, cout, ovf        result, carry-out (no-borrow in sub), signed overflow
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH,
  parameter int CHUNK = ADDER_DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = adderStages(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gBadParams
    $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Per-stage registers. Operand registers act as skew (upper chunks not yet
  // consumed); the sum register acts as deskew (lower chunks already finished).
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic             cmsb_q  [STAGES];
  logic             cmsb_d  [STAGES];

  logic [WIDTH-1:0] op_a    [STAGES];
  logic [WIDTH-1:0] op_b    [STAGES];
  logic             op_c    [STAGES];
  logic [CHUNK-1:0] slice_s [STAGES];
  logic             slice_co   [STAGES];
  logic             slice_cmsb [STAGES];

  logic stall;

  // A result sitting at the output that nobody takes freezes the whole pipe.
  assign stall    = valid_q[LAST] & ~out_ready;
  assign in_ready = ~stall;

  // Slice inputs: stage 0 sees the raw operands (B inverted and carry forced
  // to 1 for subtraction), later stages see the previous stage's registers.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      op_a[k] = '0;
      op_b[k] = '0;
      op_c[k] = 1'b0;
    end
    op_a[0] = a;
    op_b[0] = sub ? ~b : b;
    op_c[0] = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      op_c[k] = carry_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gSlice
    adder_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a        (op_a[k][k*CHUNK +: CHUNK]),
      .b        (op_b[k][k*CHUNK +: CHUNK]),
      .ci       (op_c[k]),
      .s        (slice_s[k]),
      .co       (slice_co[k]),
      .c_msb_in (slice_cmsb[k])
    );
  end

  // Next-state: each stage inherits the previous stage's partial sum and
  // drops its own finished chunk into place.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]     = op_a[k];
      b_d[k]     = op_b[k];
      carry_d[k] = slice_co[k];
      cmsb_d[k]  = slice_cmsb[k];
      valid_d[k] = (k == 0) ? in_valid : 1'b0;
      sum_d[k]   = '0;
    end
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      sum_d[k]   = sum_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k][k*CHUNK +: CHUNK] = slice_s[k];
    end
  end

  // Reset discards everything in flight; otherwise all stages advance
  // together unless the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        cmsb_q[k]  <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
        cmsb_q[k]  <= cmsb_d[k];
      end
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = carry_q[LAST] ^ cmsb_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder: an 8/4 instance for directed, stall, reset and
// random traffic, and a 4/2 instance fed every operand pair back-to-back.
module tb_pipelined_adder;

  localparam int STAGES8 = 2;
  localparam int STAGES4 = 2;

  logic       clk;
  logic       rst_n;
  logic       inValid, inReady, outValid, outReady;
  logic [7:0] a, b, sum;
  logic       cin, sub, cout, ovf;

  logic       inValid4, inReady4, outValid4;
  logic [3:0] a4, b4, sum4;
  logic       cout4, ovf4;

  int nChecks, nFails, cyc, stallCnt, popped4;
  bit shown8;

  typedef struct {
    int s;
    bit co;
    bit ov;
    int p;
    int snap;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  pipelined_adder #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(outValid),
    .out_ready(outReady), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(4), .CHUNK(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid4), .in_ready(inReady4),
    .a(a4), .b(b4), .cin(1'b0), .sub(1'b0), .out_valid(outValid4),
    .out_ready(1'b1), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers: unsigned result modulo 2^w,
  // carry/no-borrow from unsigned comparison, overflow from the signed range.
  task automatic modelAdd(input int w, input int ua, input int ub, input bit c, input bit s,
                          output int r, output bit co, output bit ov);
    int half, full, sa, sb, sr;
    half = 1 << (w - 1);
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    if (s) begin
      full = ua - ub;
      sr   = sa - sb;
      co   = (ua >= ub);
    end else begin
      full = ua + ub + int'(c);
      sr   = sa + sb + int'(c);
      co   = (full >= 2 * half);
    end
    r  = full & (2 * half - 1);
    ov = (sr >= half) || (sr < -half);
  endtask

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic c, input logic s, input logic v);
    a       = av;
    b       = bv;
    cin     = c;
    sub     = s;
    inValid = v;
  endtask

  // One isolated operation on an idle pipe, with hand-computed expectations.
  task automatic directed(input logic [7:0] av, input logic [7:0] bv, input logic c,
                          input logic s, input logic [7:0] es, input logic ec, input logic eo);
    applyStimulus(av, bv, c, s, 1'b1);
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("lat early out_valid", outValid, 0);
    @(posedge clk); #1;
    checkOutput("lat out_valid", outValid, 1);
    checkOutput("dir sum", sum, es);
    checkOutput("dir cout", cout, ec);
    checkOutput("dir ovf", ovf, eo);
  endtask

  // Compare process: every cycle, check both DUTs against the queue-based
  // model. An entry is due STAGES cycles after acceptance, plus one cycle for
  // every stalled cycle seen since then; once shown it stays until taken.
  always @(negedge clk) begin
    exp_t e;
    bit   expV;
    bit   expV4;
    int   r;
    bit   co;
    bit   ov;
    cyc++;
    if (!rst_n) begin
      checkOutput("rst out_valid", outValid, 0);
      checkOutput("rst sum", sum, 0);
      checkOutput("rst cout", cout, 0);
      checkOutput("rst ovf", ovf, 0);
      checkOutput("rst in_ready", inReady, 1);
      checkOutput("rst out_valid4", outValid4, 0);
      q8.delete();
      q4.delete();
      shown8 = 1'b0;
    end else begin
      expV = (q8.size() > 0) &&
             (shown8 || (cyc >= q8[0].p + STAGES8 + (stallCnt - q8[0].snap)));
      checkOutput("out_valid", outValid, expV);
      checkOutput("in_ready", inReady, !(expV && !outReady));
      if (outValid && expV) begin
        checkOutput("sum", sum, q8[0].s);
        checkOutput("cout", cout, q8[0].co);
        checkOutput("ovf", ovf, q8[0].ov);
        shown8 = 1'b1;
      end
      if (outValid && outReady && q8.size() > 0) begin
        void'(q8.pop_front());
        shown8 = 1'b0;
      end
      if (expV && !outReady) stallCnt++;
      if (inValid && inReady) begin
        modelAdd(8, int'(a), int'(b), cin, sub, r, co, ov);
        e = '{s: r, co: co, ov: ov, p: cyc, snap: stallCnt};
        q8.push_back(e);
      end

      expV4 = (q4.size() > 0) && (cyc >= q4[0].p + STAGES4);
      checkOutput("out_valid4", outValid4, expV4);
      if (outValid4 && expV4) begin
        checkOutput("sum4", sum4, q4[0].s);
        checkOutput("cout4", cout4, q4[0].co);
        checkOutput("ovf4", ovf4, q4[0].ov);
      end
      if (outValid4 && q4.size() > 0) begin
        void'(q4.pop_front());
        popped4++;
      end
      if (inValid4 && inReady4) begin
        modelAdd(4, int'(a4), int'(b4), 1'b0, 1'b0, r, co, ov);
        e = '{s: r, co: co, ov: ov, p: cyc, snap: 0};
        q4.push_back(e);
      end
    end
  end

  // Main sequence: reset, directed cases, stall, mid-stream reset, random
  // traffic, then the exhaustive 4-bit sweep.
  initial begin
    nChecks  = 0;
    nFails   = 0;
    cyc      = 0;
    stallCnt = 0;
    popped4  = 0;
    shown8   = 1'b0;
    rst_n    = 1'b0;
    outReady = 1'b1;
    inValid4 = 1'b0;
    a4       = '0;
    b4       = '0;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("init out_valid", outValid, 0);
    checkOutput("init sum", sum, 0);
    checkOutput("init in_ready", inReady, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    directed(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    directed(8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    directed(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    directed(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    directed(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    directed(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    directed(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    directed(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Fill the pipe, then hold the output for three cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      @(posedge clk); #1;
    end
    outReady = 1'b0;
    #1;
    checkOutput("stall in_ready", inReady, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stall out_valid", outValid, 1);
      checkOutput("stall in_ready held", inReady, 0);
    end
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Two operations in flight, then an asynchronous reset pulse.
    applyStimulus(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    inValid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", outValid, 0);
    checkOutput("async rst sum", sum, 0);
    checkOutput("async rst in_ready", inReady, 1);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    directed(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("post rst no stale", outValid, 0);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) != 0));
      outReady = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("drain8", q8.size(), 0);

    // Every 4-bit operand pair, one per cycle.
    for (int i = 0; i < 256; i++) begin
      a4       = 4'(i >> 4);
      b4       = 4'(i);
      inValid4 = 1'b1;
      @(posedge clk); #1;
    end
    inValid4 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("count4", popped4, 256);
    checkOutput("drain4", q4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
